// File: rtl/snn_buf_pkg.sv
// Shared definitions for the SNN history buffers: the operating-mode enum,
// default geometry, and the helper that sizes occupancy counters.
package snn_buf_pkg;

    // Operating mode latched on reset/clear: either replay through RAM or pass through.
    typedef enum logic {
        MODE_DELAY  = 1'b0,
        MODE_BYPASS = 1'b1
    } buf_mode_e;

    localparam int DEFAULT_WIDTH  = 48;
    localparam int DEFAULT_ADDR_W = 9;

    // An occupancy counter has to reach 2**addr_w, so it needs one extra bit.
    function automatic int fill_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/delay_line_buf_dp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, each with
// its own enable. The read register holds its value while rd_en is low.
// Reading and writing the same address in one cycle gives an undefined read;
// callers that need write-first behaviour must forward around this block.
module dp_ram #(
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Write port: store the word when enabled.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered read, holds the previous word when idle.
    always_ff @(posedge CLK) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_line_buf.sv
// Programmable delay line: each accepted word reappears on Q exactly N accepted
// words later (N = DEPTH+1, latched on reset/clear). Writes are deferred by one
// cycle through a pending-write register so the RAM read and write ports never
// collide except when N = 1, where the pending data is forwarded straight to Q.
// Bypass mode registers D onto Q and leaves the RAM idle.
module delay_line_buf
    import snn_buf_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLEAR,
    input  logic              IN_VALID,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] DEPTH,
    input  logic              BYPASS,
    output logic [WIDTH-1:0]  Q,
    output logic              OUT_VALID,
    output logic              FILLED
);

    localparam int FILL_W = fill_width(ADDR_W);

    // Configuration latched on restart
    logic [ADDR_W-1:0] depth_q;
    buf_mode_e         mode_q;

    // Ring pointer and occupancy
    logic [ADDR_W-1:0] ptr;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_target;
    logic              at_target;

    // Deferred write captured at acceptance, committed the next cycle
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [WIDTH-1:0]  pend_data;

    // Output path state
    logic [WIDTH-1:0]  ram_rd_data;
    logic [WIDTH-1:0]  hold_data;
    logic              use_hold;
    logic              q_zero;
    logic              out_valid_q;

    // Control strobes
    logic              restart;
    logic              accept;
    logic              ram_re;
    logic              ram_we;
    logic              fwd_hit;

    assign restart   = RST | CLEAR;
    assign accept    = IN_VALID & ~restart;
    assign ram_re    = accept & (mode_q == MODE_DELAY);
    assign ram_we    = pend_valid & ~restart;
    assign fwd_hit   = pend_valid & (pend_addr == ptr);
    assign at_target = (fill == fill_target);

    // Fill level at which the line counts as full: N in delay mode, 1 in bypass.
    always_comb begin
        fill_target = FILL_W'(1);
        if (mode_q == MODE_DELAY) begin
            fill_target = {1'b0, depth_q} + FILL_W'(1);
        end
    end

    // Latch delay length and mode only on restart so mid-stream changes are ignored.
    always_ff @(posedge CLK) begin
        if (restart) begin
            depth_q <= DEPTH;
            mode_q  <= BYPASS ? MODE_BYPASS : MODE_DELAY;
        end
    end

    // Ring pointer walks 0..depth_q and wraps, advancing on each delay-mode read.
    always_ff @(posedge CLK) begin
        if (restart) begin
            ptr <= '0;
        end else if (ram_re) begin
            if (ptr == depth_q) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Capture each accepted word and its slot; it is written one cycle later.
    always_ff @(posedge CLK) begin
        if (restart) begin
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= ram_re;
            if (ram_re) begin
                pend_addr <= ptr;
                pend_data <= D;
            end
        end
    end

    // Count accepted words, saturating once the line is full.
    always_ff @(posedge CLK) begin
        if (restart) begin
            fill <= '0;
        end else if (accept && !at_target) begin
            fill <= fill + FILL_W'(1);
        end
    end

    // Select where Q comes from for this event and whether it is a genuine delayed word.
    always_ff @(posedge CLK) begin
        if (restart) begin
            q_zero      <= 1'b1;
            use_hold    <= 1'b0;
            hold_data   <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            q_zero      <= 1'b0;
            out_valid_q <= (mode_q == MODE_BYPASS) | at_target;
            if (mode_q == MODE_BYPASS) begin
                use_hold  <= 1'b1;
                hold_data <= D;
            end else if (fwd_hit) begin
                use_hold  <= 1'b1;
                hold_data <= pend_data;
            end else begin
                use_hold  <= 1'b0;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    dp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (ram_we),
        .wr_addr (pend_addr),
        .wr_data (pend_data),
        .rd_en   (ram_re),
        .rd_addr (ptr),
        .rd_data (ram_rd_data)
    );

    assign Q         = q_zero ? '0 : (use_hold ? hold_data : ram_rd_data);
    assign OUT_VALID = out_valid_q;
    assign FILLED    = at_target;

endmodule

// File: tb/tb_delay_line_buf.sv
// Directed testbench for delay_line_buf: fixed delays, N = 1 forwarding,
// gapped traffic, full-depth wrap, mid-stream clear and bypass mode.
module tb_delay_line_buf;

    localparam int WIDTH  = 48;
    localparam int ADDR_W = 9;

    logic              CLK;
    logic              RST;
    logic              CLEAR;
    logic              IN_VALID;
    logic [WIDTH-1:0]  D;
    logic [ADDR_W-1:0] DEPTH;
    logic              BYPASS;
    logic [WIDTH-1:0]  Q;
    logic              OUT_VALID;
    logic              FILLED;

    int checks = 0;
    int errors = 0;
    int enableHits = 0;
    bit monitorRam = 0;

    delay_line_buf #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLEAR     (CLEAR),
        .IN_VALID  (IN_VALID),
        .D         (D),
        .DEPTH     (DEPTH),
        .BYPASS    (BYPASS),
        .Q         (Q),
        .OUT_VALID (OUT_VALID),
        .FILLED    (FILLED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count any RAM port activity while bypass mode should keep the RAM idle.
    always @(negedge CLK) begin
        if (monitorRam && (dut.ram_re || dut.ram_we)) begin
            enableHits++;
        end
    end

    // Drive one cycle of input on the falling edge, return just after the rising edge.
    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
        @(negedge CLK);
        RST      = 1'b0;
        CLEAR    = 1'b0;
        IN_VALID = valid;
        D        = data;
        @(posedge CLK);
        #1;
    endtask

    // One cycle of CLEAR with a new configuration and an optional concurrent input.
    task automatic applyClear(input logic [ADDR_W-1:0] depth, input logic bypass,
                              input logic valid, input logic [WIDTH-1:0] data);
        @(negedge CLK);
        RST      = 1'b0;
        CLEAR    = 1'b1;
        DEPTH    = depth;
        BYPASS   = bypass;
        IN_VALID = valid;
        D        = data;
        @(posedge CLK);
        #1;
        CLEAR    = 1'b0;
        IN_VALID = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] hist[$];
        logic [WIDTH-1:0] d;
        logic [63:0]      r;
        int               gap;

        RST      = 1'b1;
        CLEAR    = 1'b0;
        IN_VALID = 1'b0;
        D        = '0;
        DEPTH    = 9'd3;
        BYPASS   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset Q", Q, '0);
        checkOutput("reset OUT_VALID", WIDTH'(OUT_VALID), '0);
        checkOutput("reset FILLED", WIDTH'(FILLED), '0);

        // DEPTH=3 (N=4); changing DEPTH afterwards without CLEAR must not matter
        $display("[TB] DEPTH=3 back-to-back stream");
        DEPTH = 9'd7;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b1, WIDTH'(k));
            checkOutput($sformatf("n4 OUT_VALID ev%0d", k), WIDTH'(OUT_VALID), WIDTH'(k >= 5));
            checkOutput($sformatf("n4 FILLED ev%0d", k), WIDTH'(FILLED), WIDTH'(k >= 4));
            if (k >= 5) begin
                checkOutput($sformatf("n4 Q ev%0d", k), Q, WIDTH'(k - 4));
            end
        end
        applyStimulus(1'b0, '0);
        checkOutput("n4 gap OUT_VALID", WIDTH'(OUT_VALID), '0);
        checkOutput("n4 gap Q hold", Q, WIDTH'(8));

        // DEPTH=0 (N=1): back-to-back needs forwarding, after a gap it reads RAM
        $display("[TB] DEPTH=0 forwarding");
        applyClear(9'd0, 1'b0, 1'b0, '0);
        checkOutput("clr Q", Q, '0);
        checkOutput("clr OUT_VALID", WIDTH'(OUT_VALID), '0);
        checkOutput("clr FILLED", WIDTH'(FILLED), '0);
        applyStimulus(1'b1, 48'hA);
        checkOutput("n1 OUT_VALID ev1", WIDTH'(OUT_VALID), '0);
        checkOutput("n1 FILLED ev1", WIDTH'(FILLED), 48'd1);
        applyStimulus(1'b1, 48'hB);
        checkOutput("n1 OUT_VALID ev2", WIDTH'(OUT_VALID), 48'd1);
        checkOutput("n1 Q ev2", Q, 48'hA);
        applyStimulus(1'b1, 48'hC);
        checkOutput("n1 OUT_VALID ev3", WIDTH'(OUT_VALID), 48'd1);
        checkOutput("n1 Q ev3", Q, 48'hB);
        applyStimulus(1'b0, 48'hF);
        checkOutput("n1 gap OUT_VALID", WIDTH'(OUT_VALID), '0);
        checkOutput("n1 gap Q hold", Q, 48'hB);
        applyStimulus(1'b1, 48'hD);
        checkOutput("n1 Q ev4", Q, 48'hC);

        // DEPTH=2 (N=3) with random gaps between events
        $display("[TB] DEPTH=2 gapped traffic");
        applyClear(9'd2, 1'b0, 1'b0, '0);
        for (int e = 0; e < 50; e++) begin
            r = {$urandom, $urandom};
            d = r[WIDTH-1:0];
            applyStimulus(1'b1, d);
            checkOutput($sformatf("n3 OUT_VALID ev%0d", e), WIDTH'(OUT_VALID), WIDTH'(e >= 3));
            checkOutput($sformatf("n3 FILLED ev%0d", e), WIDTH'(FILLED), WIDTH'(e >= 2));
            if (e >= 3) begin
                checkOutput($sformatf("n3 Q ev%0d", e), Q, hist[e-3]);
            end
            hist.push_back(d);
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                r = {$urandom, $urandom};
                applyStimulus(1'b0, r[WIDTH-1:0]);
                checkOutput($sformatf("n3 gap OUT_VALID ev%0d", e), WIDTH'(OUT_VALID), '0);
                if (e >= 3) begin
                    checkOutput($sformatf("n3 gap Q ev%0d", e), Q, hist[e-3]);
                end
            end
        end

        // Full depth: DEPTH=511 (N=512), two complete laps of the ring
        $display("[TB] DEPTH=511 wrap");
        applyClear(9'd511, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 1024; k++) begin
            applyStimulus(1'b1, WIDTH'(k) | 48'h5A00_0000_0000);
            checkOutput($sformatf("n512 OUT_VALID ev%0d", k), WIDTH'(OUT_VALID), WIDTH'(k >= 513));
            if (k >= 513) begin
                checkOutput($sformatf("n512 Q ev%0d", k), Q, WIDTH'(k - 512) | 48'h5A00_0000_0000);
            end
        end
        checkOutput("n512 FILLED", WIDTH'(FILLED), 48'd1);

        // Mid-stream CLEAR right after an acceptance, DEPTH 3 -> 1, input discarded
        $display("[TB] mid-stream clear");
        applyClear(9'd3, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, WIDTH'(48'h100 + k));
        end
        checkOutput("mid Q before clear", Q, 48'h102);
        applyClear(9'd1, 1'b0, 1'b1, 48'hDEAD);
        checkOutput("mid clr Q", Q, '0);
        checkOutput("mid clr OUT_VALID", WIDTH'(OUT_VALID), '0);
        checkOutput("mid clr FILLED", WIDTH'(FILLED), '0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, WIDTH'(48'h200 + k));
            checkOutput($sformatf("mid OUT_VALID ev%0d", k), WIDTH'(OUT_VALID), WIDTH'(k >= 3));
            checkOutput($sformatf("mid FILLED ev%0d", k), WIDTH'(FILLED), WIDTH'(k >= 2));
            if (k >= 3) begin
                checkOutput($sformatf("mid Q ev%0d", k), Q, WIDTH'(48'h200 + k - 2));
            end
        end

        // Bypass mode: Q is D registered, RAM ports stay quiet
        $display("[TB] bypass mode");
        applyStimulus(1'b0, '0);
        applyClear(9'd5, 1'b1, 1'b0, '0);
        monitorRam = 1'b1;
        applyStimulus(1'b1, 48'h55);
        checkOutput("byp Q ev1", Q, 48'h55);
        checkOutput("byp OUT_VALID ev1", WIDTH'(OUT_VALID), 48'd1);
        checkOutput("byp FILLED ev1", WIDTH'(FILLED), 48'd1);
        applyStimulus(1'b1, 48'h66);
        checkOutput("byp Q ev2", Q, 48'h66);
        checkOutput("byp OUT_VALID ev2", WIDTH'(OUT_VALID), 48'd1);
        applyStimulus(1'b0, 48'h77);
        checkOutput("byp gap OUT_VALID", WIDTH'(OUT_VALID), '0);
        checkOutput("byp gap Q hold", Q, 48'h66);
        monitorRam = 1'b0;
        checkOutput("byp RAM enables", WIDTH'(enableHits), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
